elink_trig_voter_p: RTL and testbench
=====================================

# elink_trig_voter_p

Parametrised, registered triple-modular-redundancy voter for the e-link trigger path, succeeding the fixed 10-bit trigger voter. It takes three redundant copies of a trigger word, produces the bitwise 2-of-3 majority with a one-cycle registered latency and a valid qualifier, and reports which copies disagreed. It also keeps per-copy saturating error counters and sticky persistent-fault flags for slow-control readout.

## Interface
- `WIDTH`, default 10: data word width, ≥ 1.
- `CNT_W`, default 16: width of each per-copy error counter, ≥ 2.
- `PERSIST`, default 4: consecutive mismatching valid words that set a copy's fault flag, ≥ 1.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `valid_in`, in, 1: the three data inputs carry a word this cycle.
- `data_in1`, `data_in2`, `data_in3`, in, WIDTH each: redundant copies.
- `clear_counts`, in, 1: synchronous clear of counters, run lengths and fault flags.
- `voted`, out, WIDTH: registered majority word.
- `voted_valid`, out, 1: `voted` holds a new word this cycle.
- `mismatch`, out, 3: bit i-1 is set when `data_in<i>` differed from the vote for the word now on `voted`.
- `multi_err`, out, 1: two or more copies differed from the vote for that word.
- `err_cnt1`, `err_cnt2`, `err_cnt3`, out, CNT_W each: saturating mismatch counts per copy.
- `fault`, out, 3: sticky per-copy persistent-fault flags.

## Operation
- Majority per bit: `maj = (d1&d2) | (d1&d3) | (d2&d3)`.
- Per-copy mismatch: `mm[i] = |(d_i ^ maj)`, computed combinationally from the inputs.
- Register stage, on the edge where `valid_in`=1:
  - `voted` ← maj;
  - `mismatch` ← mm;
  - `multi_err` ← (popcount(mm) ≥ 2);
  - `voted_valid` ← 1.
- Register stage, on the edge where `valid_in`=0:
  - `voted_valid` ← 0;
  - `voted`, `mismatch` and `multi_err` hold their previous values.
- Error counter i, on a valid word with mm[i]=1: increment by 1, saturating at 2^CNT_W−1 (no wrap).
- Run counter i is internal, width clog2(PERSIST+1), and saturates at PERSIST. On a valid word:
  - mm[i]=1: increment;
  - mm[i]=0: clear to 0.
- Run counter i holds when `valid_in`=0.
- `fault[i]` sets on the edge where run counter i reaches PERSIST. It stays set until `clear_counts` or reset.
- `clear_counts`=1 has priority over counting:
  - error counters, run counters and `fault` are cleared to 0 at that edge;
  - the word presented in the same cycle is not counted;
  - `voted`, `mismatch`, `multi_err` and `voted_valid` still update normally.
- Reset (`rst_n`=0, at any time including mid-stream): all outputs and internal state go to 0 immediately. No state survives reset.

## Timing
- Latency: the word sampled with `valid_in` at edge k appears on `voted`/`mismatch`/`multi_err`, with `voted_valid`=1, after edge k.
- Throughput: one word per cycle; `valid_in` may stay high continuously.
- Counter and fault visibility: `err_cnt*` and `fault` update at the same edge as `voted`, so they include the word currently shown on `voted`.
- PERSIST=1: `fault[i]` sets at the same edge as the first mismatching word.
- Reset values: `voted`=0, `voted_valid`=0, `mismatch`=3'b000, `multi_err`=0, `err_cnt*`=0, `fault`=3'b000.
- Reset release: the first edge with `rst_n`=1 may capture data.

## Test plan
- Reset and agreement: reset, then apply all copies=10'h3FF with `valid_in`=1 for 1 cycle. Required: after that edge `voted`=3FF, `voted_valid`=1, `mismatch`=000, all counters 0. On the next edge with `valid_in`=0, `voted_valid`=0 and `voted` stays 3FF.
- Single-copy error: apply d1=000, d2=d3=3FF, valid. Required: `voted`=3FF, `mismatch`=001, `multi_err`=0, `err_cnt1`=1.
- Split disagreement: apply d1=001, d2=002, d3=000. Required: `voted`=000, `mismatch`=011, `multi_err`=1, `err_cnt1`=`err_cnt2`=1, `err_cnt3`=0.
- Persistence (PERSIST=4):
  - d3 corrupted for 3 valid words, 1 clean word, then 4 corrupted words, with idle cycles interleaved. Required: `fault[2]` rises only on the 4th word of the second run, and `err_cnt3`=7.
  - Then assert `clear_counts` on the same cycle as another corrupted valid word. Required: `err_cnt3`=0 and `fault`=000 after that edge, while `voted`/`mismatch` still update.
- Saturation: with CNT_W=2, corrupt d2 for 6 valid words. Required: `err_cnt2` sequence 1, 2, 3, 3, 3, 3.
- Reset mid-stream: drop `rst_n` asynchronously between edges while `voted_valid`=1 and `fault`≠0. Required: all outputs read 0 before the next edge. After release, clean words give `mismatch`=000 and counters stay 0.

Source files
------------

// File: rtl/elink_trig_voter_p.sv
// Registered 2-of-3 TMR voter for the e-link trigger path, with per-copy
// saturating error counters and sticky persistent-fault flags.
module elink_trig_voter_p #(
    parameter int WIDTH   = 10,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    input  logic             clear_counts,
    output logic [WIDTH-1:0] voted,
    output logic             voted_valid,
    output logic [2:0]       mismatch,
    output logic             multi_err,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [CNT_W-1:0] err_cnt3,
    output logic [2:0]       fault
);

    localparam int RUN_W = $clog2(PERSIST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);

    logic [2:0][WIDTH-1:0] din;
    logic [WIDTH-1:0]      maj;
    logic [2:0]            mm;
    logic                  multi;

    assign din   = {data_in3, data_in2, data_in1};
    assign maj   = (data_in1 & data_in2) | (data_in1 & data_in3) | (data_in2 & data_in3);
    assign multi = (mm[0] & mm[1]) | (mm[0] & mm[2]) | (mm[1] & mm[2]);

    always_comb begin
        mm = '0;
        for (int i = 0; i < 3; i++) mm[i] = |(din[i] ^ maj);
    end

    logic [WIDTH-1:0] voted_q;
    logic             vvalid_q;
    logic [2:0]       mism_q;
    logic             multi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted_q  <= '0;
            vvalid_q <= 1'b0;
            mism_q   <= '0;
            multi_q  <= 1'b0;
        end else begin
            vvalid_q <= valid_in;
            if (valid_in) begin
                voted_q <= maj;
                mism_q  <= mm;
                multi_q <= multi;
            end
        end
    end

    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0][RUN_W-1:0] run_q, run_d;
    logic [2:0]            flt_q, flt_d;

    // Clear wins over counting; the run length resets on any agreeing word.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        flt_d = flt_q;
        for (int i = 0; i < 3; i++) begin
            if (clear_counts) begin
                cnt_d[i] = '0;
                run_d[i] = '0;
                flt_d[i] = 1'b0;
            end else if (valid_in) begin
                if (mm[i]) begin
                    if (cnt_q[i] != {CNT_W{1'b1}}) cnt_d[i] = cnt_q[i] + 1'b1;
                    if (run_q[i] != RUN_MAX)       run_d[i] = run_q[i] + 1'b1;
                end else begin
                    run_d[i] = '0;
                end
                flt_d[i] = flt_q[i] | (run_d[i] == RUN_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= '0;
            flt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
            flt_q <= flt_d;
        end
    end

    assign voted       = voted_q;
    assign voted_valid = vvalid_q;
    assign mismatch    = mism_q;
    assign multi_err   = multi_q;
    assign err_cnt1    = cnt_q[0];
    assign err_cnt2    = cnt_q[1];
    assign err_cnt3    = cnt_q[2];
    assign fault       = flt_q;

endmodule

// File: tb/tb_elink_trig_voter_p.sv
// Directed bench for elink_trig_voter_p: default instance plus a
// CNT_W=2 / PERSIST=1 instance sharing the same stimulus.
module tb_elink_trig_voter_p;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [9:0] d1 = '0, d2 = '0, d3 = '0;
    logic       clear_counts = 1'b0;

    logic [9:0]  a_voted;
    logic        a_vv;
    logic [2:0]  a_mm;
    logic        a_multi;
    logic [15:0] a_c1, a_c2, a_c3;
    logic [2:0]  a_fault;

    logic [9:0]  b_voted;
    logic        b_vv;
    logic [2:0]  b_mm;
    logic        b_multi;
    logic [1:0]  b_c1, b_c2, b_c3;
    logic [2:0]  b_fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    elink_trig_voter_p u_a (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in1(d1), .data_in2(d2), .data_in3(d3), .clear_counts(clear_counts),
        .voted(a_voted), .voted_valid(a_vv), .mismatch(a_mm), .multi_err(a_multi),
        .err_cnt1(a_c1), .err_cnt2(a_c2), .err_cnt3(a_c3), .fault(a_fault)
    );

    elink_trig_voter_p #(.WIDTH(10), .CNT_W(2), .PERSIST(1)) u_b (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in1(d1), .data_in2(d2), .data_in3(d3), .clear_counts(clear_counts),
        .voted(b_voted), .voted_valid(b_vv), .mismatch(b_mm), .multi_err(b_multi),
        .err_cnt1(b_c1), .err_cnt2(b_c2), .err_cnt3(b_c3), .fault(b_fault)
    );

    task automatic word(input logic [9:0] x1, input logic [9:0] x2, input logic [9:0] x3);
        valid_in = 1'b1; d1 = x1; d2 = x2; d3 = x3;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear_counts = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        clear_counts = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++; if (a_voted !== 10'h000) begin n_fail++; $display("FAIL reset_voted got %h exp 000", a_voted); end
        n_tests++; if (a_vv !== 1'b0) begin n_fail++; $display("FAIL reset_vv got %b exp 0", a_vv); end
        n_tests++; if (a_mm !== 3'b000 || a_multi !== 1'b0) begin n_fail++; $display("FAIL reset_mm got %b/%b exp 000/0", a_mm, a_multi); end
        n_tests++; if ({a_c1, a_c2, a_c3} !== 48'd0 || a_fault !== 3'b000) begin n_fail++; $display("FAIL reset_cnt got %h %h %h f=%b exp 0", a_c1, a_c2, a_c3, a_fault); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_agree();
        word(10'h3FF, 10'h3FF, 10'h3FF);
        n_tests++; if (a_voted !== 10'h3FF || a_vv !== 1'b1) begin n_fail++; $display("FAIL agree_voted got %h/%b exp 3ff/1", a_voted, a_vv); end
        n_tests++; if (a_mm !== 3'b000 || a_multi !== 1'b0) begin n_fail++; $display("FAIL agree_mm got %b/%b exp 000/0", a_mm, a_multi); end
        n_tests++; if ({a_c1, a_c2, a_c3} !== 48'd0) begin n_fail++; $display("FAIL agree_cnt got %h %h %h exp 0", a_c1, a_c2, a_c3); end
        idle();
        n_tests++; if (a_vv !== 1'b0 || a_voted !== 10'h3FF) begin n_fail++; $display("FAIL agree_hold got %h/%b exp 3ff/0", a_voted, a_vv); end
    endtask

    task automatic test_single();
        word(10'h000, 10'h3FF, 10'h3FF);
        n_tests++; if (a_voted !== 10'h3FF || a_vv !== 1'b1) begin n_fail++; $display("FAIL single_voted got %h/%b exp 3ff/1", a_voted, a_vv); end
        n_tests++; if (a_mm !== 3'b001 || a_multi !== 1'b0) begin n_fail++; $display("FAIL single_mm got %b/%b exp 001/0", a_mm, a_multi); end
        n_tests++; if (a_c1 !== 16'd1 || a_c2 !== 16'd0 || a_c3 !== 16'd0) begin n_fail++; $display("FAIL single_cnt got %0d %0d %0d exp 1 0 0", a_c1, a_c2, a_c3); end
    endtask

    task automatic test_split();
        do_clear();
        n_tests++; if (a_c1 !== 16'd0 || a_vv !== 1'b0) begin n_fail++; $display("FAIL clear_idle got c1=%0d vv=%b exp 0/0", a_c1, a_vv); end
        word(10'h001, 10'h002, 10'h000);
        n_tests++; if (a_voted !== 10'h000) begin n_fail++; $display("FAIL split_voted got %h exp 000", a_voted); end
        n_tests++; if (a_mm !== 3'b011 || a_multi !== 1'b1) begin n_fail++; $display("FAIL split_mm got %b/%b exp 011/1", a_mm, a_multi); end
        n_tests++; if (a_c1 !== 16'd1 || a_c2 !== 16'd1 || a_c3 !== 16'd0) begin n_fail++; $display("FAIL split_cnt got %0d %0d %0d exp 1 1 0", a_c1, a_c2, a_c3); end
    endtask

    task automatic test_persist();
        do_clear();
        for (int k = 0; k < 3; k++) begin
            word(10'h155, 10'h155, 10'h0AA);
            n_tests++; if (a_fault !== 3'b000) begin n_fail++; $display("FAIL persist_run1_%0d fault got %b exp 000", k, a_fault); end
            if (k == 0) begin
                n_tests++; if (b_fault !== 3'b100) begin n_fail++; $display("FAIL persist1_fault got %b exp 100", b_fault); end
            end
            idle();
        end
        word(10'h155, 10'h155, 10'h155);
        n_tests++; if (a_fault !== 3'b000 || a_mm !== 3'b000) begin n_fail++; $display("FAIL persist_clean got f=%b mm=%b exp 000/000", a_fault, a_mm); end
        for (int k = 0; k < 4; k++) begin
            idle();
            word(10'h155, 10'h155, 10'h0AA);
            n_tests++;
            if (a_fault !== ((k == 3) ? 3'b100 : 3'b000)) begin
                n_fail++; $display("FAIL persist_run2_%0d fault got %b exp %b", k, a_fault, (k == 3) ? 3'b100 : 3'b000);
            end
        end
        n_tests++; if (a_c3 !== 16'd7 || a_mm !== 3'b100) begin n_fail++; $display("FAIL persist_cnt3 got %0d mm=%b exp 7/100", a_c3, a_mm); end
        idle();
        n_tests++; if (a_fault !== 3'b100) begin n_fail++; $display("FAIL persist_sticky got %b exp 100", a_fault); end
        clear_counts = 1'b1;
        word(10'h000, 10'h155, 10'h155);
        clear_counts = 1'b0;
        n_tests++; if (a_c1 !== 16'd0 || a_c3 !== 16'd0 || a_fault !== 3'b000) begin n_fail++; $display("FAIL clear_cnt got c1=%0d c3=%0d f=%b exp 0 0 000", a_c1, a_c3, a_fault); end
        n_tests++; if (a_voted !== 10'h155 || a_mm !== 3'b001 || a_vv !== 1'b1) begin n_fail++; $display("FAIL clear_vote got %h mm=%b vv=%b exp 155/001/1", a_voted, a_mm, a_vv); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_b [6];
        exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3;
        exp_b[3] = 2'd3; exp_b[4] = 2'd3; exp_b[5] = 2'd3;
        do_clear();
        for (int k = 0; k < 6; k++) begin
            word(10'h0F0, 10'h00F, 10'h0F0);
            n_tests++; if (b_c2 !== exp_b[k]) begin n_fail++; $display("FAIL sat_cnt2_%0d got %0d exp %0d", k, b_c2, exp_b[k]); end
        end
        n_tests++; if (a_c2 !== 16'd6 || a_fault !== 3'b010) begin n_fail++; $display("FAIL sat_wide got %0d f=%b exp 6/010", a_c2, a_fault); end
    endtask

    task automatic test_reset_mid();
        word(10'h0F0, 10'h00F, 10'h0F0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (a_vv !== 1'b0 || a_voted !== 10'h000 || a_mm !== 3'b000 || a_multi !== 1'b0) begin n_fail++; $display("FAIL midrst_out got %h vv=%b mm=%b me=%b exp 0", a_voted, a_vv, a_mm, a_multi); end
        n_tests++; if ({a_c1, a_c2, a_c3} !== 48'd0 || a_fault !== 3'b000 || b_fault !== 3'b000) begin n_fail++; $display("FAIL midrst_cnt got %h %h %h f=%b/%b exp 0", a_c1, a_c2, a_c3, a_fault, b_fault); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            word(10'h2A5, 10'h2A5, 10'h2A5);
            n_tests++; if (a_mm !== 3'b000 || a_voted !== 10'h2A5 || a_vv !== 1'b1) begin n_fail++; $display("FAIL postrst_%0d got %h mm=%b vv=%b exp 2a5/000/1", k, a_voted, a_mm, a_vv); end
        end
        n_tests++; if ({a_c1, a_c2, a_c3} !== 48'd0 || a_fault !== 3'b000) begin n_fail++; $display("FAIL postrst_cnt got %h %h %h f=%b exp 0", a_c1, a_c2, a_c3, a_fault); end
    endtask

    initial begin
        test_reset();
        test_agree();
        test_single();
        test_split();
        test_persist();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
